// File: rtl/imem_arbiter.sv
// Arbiter/sequencer sharing the single-port instruction memory between the fetch unit
// (read-only) and the program loader (read/write), with lock mode, range check and write count.
module imem_arbiter #(
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  output logic          f_err,
  output logic          f_stall,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_ack,
  output logic [DW-1:0] l_rdata,
  output logic          l_err,
  output logic [CW-1:0] load_cnt,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e          state_q, state_d;
  logic            last_l_q, last_l_d;
  logic            sel_l_q, sel_l_d;
  logic            we_q, we_d;
  logic            inr_q, inr_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_data_in_q, mem_data_in_d;
  logic            mem_rd_q, mem_rd_d;
  logic            mem_wr_q, mem_wr_d;
  logic            f_ack_q, f_ack_d;
  logic [DW-1:0]   f_rdata_q, f_rdata_d;
  logic            f_err_q, f_err_d;
  logic            l_ack_q, l_ack_d;
  logic [DW-1:0]   l_rdata_q, l_rdata_d;
  logic            l_err_q, l_err_d;
  logic [CW-1:0]   load_cnt_q, load_cnt_d;

  logic            f_elig;
  logic            grant_l;
  logic            g_wr;
  logic [AW-1:0]   g_addr;
  logic            g_inr;
  logic [DW-1:0]   rdata_c;

  // Next-state: arbitration in IDLE, memory strobe in ACCESS, ack in RESP
  always_comb begin
    state_d       = state_q;
    last_l_d      = last_l_q;
    sel_l_d       = sel_l_q;
    we_d          = we_q;
    inr_d         = inr_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_rd_d      = 1'b0;
    mem_wr_d      = 1'b0;
    f_ack_d       = 1'b0;
    f_rdata_d     = f_rdata_q;
    f_err_d       = f_err_q;
    l_ack_d       = 1'b0;
    l_rdata_d     = l_rdata_q;
    l_err_d       = l_err_q;
    load_cnt_d    = load_cnt_q;

    f_elig  = f_req & ~l_lock;
    // Loader wins when it is the only one eligible or when fetch was served last
    grant_l = l_req & (~f_elig | ~last_l_q);
    g_wr    = grant_l & l_we;
    g_addr  = grant_l ? l_addr : f_addr;
    g_inr   = ({1'b0, g_addr} < DEPTH_W);
    rdata_c = (inr_q && !we_q) ? mem_data_out : '0;

    unique case (state_q)
      IDLE: begin
        if (f_elig || l_req) begin
          state_d  = ACCESS;
          last_l_d = grant_l;
          sel_l_d  = grant_l;
          we_d     = g_wr;
          inr_d    = g_inr;
          if (g_inr) begin
            mem_addr_d = g_addr;
            mem_rd_d   = ~g_wr;
            mem_wr_d   = g_wr;
            if (g_wr) mem_data_in_d = l_wdata;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (sel_l_q) begin
          l_ack_d   = 1'b1;
          l_rdata_d = rdata_c;
          l_err_d   = ~inr_q;
          if (we_q && inr_q && (load_cnt_q != CNT_MAX)) load_cnt_d = load_cnt_q + CW'(1);
        end else begin
          f_ack_d   = 1'b1;
          f_rdata_d = rdata_c;
          f_err_d   = ~inr_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_l_q      <= 1'b1;
      sel_l_q       <= 1'b0;
      we_q          <= 1'b0;
      inr_q         <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      f_ack_q       <= 1'b0;
      f_rdata_q     <= '0;
      f_err_q       <= 1'b0;
      l_ack_q       <= 1'b0;
      l_rdata_q     <= '0;
      l_err_q       <= 1'b0;
      load_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_l_q      <= last_l_d;
      sel_l_q       <= sel_l_d;
      we_q          <= we_d;
      inr_q         <= inr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      f_ack_q       <= f_ack_d;
      f_rdata_q     <= f_rdata_d;
      f_err_q       <= f_err_d;
      l_ack_q       <= l_ack_d;
      l_rdata_q     <= l_rdata_d;
      l_err_q       <= l_err_d;
      load_cnt_q    <= load_cnt_d;
    end
  end

  assign f_stall     = l_lock;
  assign f_ack       = f_ack_q;
  assign f_rdata     = f_rdata_q;
  assign f_err       = f_err_q;
  assign l_ack       = l_ack_q;
  assign l_rdata     = l_rdata_q;
  assign l_err       = l_err_q;
  assign load_cnt    = load_cnt_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;

endmodule
